// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with flags, flush and optional FWFT read port
//
// Optional feature macro: FIFO_SYNC_PARAM_FWFT_EN (first-word-fall-through read port).
//
// Ports:
//   clk     in   1              clock, all state updates on the rising edge
//   nrst    in   1              asynchronous active-low reset
//   rdy     out  1              block ready, high from the first edge after reset release
//   clr     in   1              synchronous flush, overrides wr_en/rd_en
//   wr_en   in   1              write request
//   din     in   WIDTH          write data
//   full    out  1              DEPTH words held
//   afull   out  1              dcnt >= AFULL_TH
//   rd_en   in   1              read request (standard) / pop acknowledge (FWFT)
//   dout    out  WIDTH          read data
//   empty   out  1              no readable word
//   aempty  out  1              dcnt <= AEMPTY_TH
//   dcnt    out  $clog2(DEPTH)+1 words held, 0..DEPTH
//   ovf     out  1              sticky, write attempted while full
//   udf     out  1              sticky, read attempted while empty
module fifo_sync_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 256,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    output logic                     rdy,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     afull,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     aempty,
    output logic [$clog2(DEPTH):0]   dcnt,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr_acc;

    // rdy goes high on the first edge after reset release; requests seen
    // while it is still low are ignored.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdy <= 1'b0;
        end else begin
            rdy <= 1'b1;
        end
    end

    // full means DEPTH words held in both modes; the FWFT stage counts too.
    assign full   = (dcnt == DEPTH_C);
    assign afull  = (dcnt >= AFULL_C);
    assign aempty = (dcnt <= AEMPTY_C);
    assign wr_acc = wr_en & ~full & rdy & ~clr;

    // Storage array has no reset: after reset the pointers make every
    // stale entry unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (rdy) begin
            if (wr_en & full) begin
                ovf <= 1'b1;
            end
            if (rd_en & empty) begin
                udf <= 1'b1;
            end
        end
    end

`ifdef FIFO_SYNC_PARAM_FWFT_EN

    // The array feeds a one-word output register holding the head word.
    // mcnt counts only array words; dcnt adds the output-stage word.
    logic [CW-1:0] mcnt;
    logic          valid;
    logic          pop;
    logic          load;

    assign empty = ~valid;
    assign dcnt  = mcnt + {{AW{1'b0}}, valid};
    assign pop   = rd_en & valid & rdy & ~clr;
    // Refill the output stage whenever it is vacant or being popped.
    assign load  = (mcnt != '0) & (~valid | pop) & rdy & ~clr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr  <= '0;
            rptr  <= '0;
            mcnt  <= '0;
            valid <= 1'b0;
            dout  <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            mcnt  <= '0;
            valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (load) begin
                rptr  <= rptr + 1'b1;
                dout  <= mem[rptr];
                valid <= 1'b1;
            end else if (pop) begin
                valid <= 1'b0;
            end
            case ({wr_acc, load})
                2'b10:   mcnt <= mcnt + 1'b1;
                2'b01:   mcnt <= mcnt - 1'b1;
                default: mcnt <= mcnt;
            endcase
        end
    end

`else

    logic          rd_acc;
    logic [CW-1:0] cnt;

    assign dcnt   = cnt;
    assign empty  = (cnt == '0);
    assign rd_acc = rd_en & ~empty & rdy & ~clr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            dout <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
                dout <= mem[rptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - self-checking bench for fifo_sync_param (DEPTH=256, WIDTH=32)
module tb_fifo_sync_param;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;

    logic             clk = 1'b0;
    logic             nrst;
    logic             rdy;
    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             afull;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             aempty;
    logic [8:0]       dcnt;
    logic             ovf;
    logic             udf;

    int               n_chk  = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] exp_w;
    logic [WIDTH-1:0] last_rd;

    always #5 clk = ~clk;

    fifo_sync_param #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .rdy    (rdy),
        .clr    (clr),
        .wr_en  (wr_en),
        .din    (din),
        .full   (full),
        .afull  (afull),
        .rd_en  (rd_en),
        .dout   (dout),
        .empty  (empty),
        .aempty (aempty),
        .dcnt   (dcnt),
        .ovf    (ovf),
        .udf    (udf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        nrst  = 1'b1;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        #2 nrst = 1'b0;
        repeat (2) tick();
        n_chk++; if (rdy !== 1'b0)   begin n_fail++; $display("FAIL reset_rdy got %b want 0", rdy); end
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_chk++; if (aempty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %b want 1", aempty); end
        n_chk++; if (full !== 1'b0)  begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_chk++; if (afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b want 0", afull); end
        n_chk++; if (dcnt !== 9'd0)  begin n_fail++; $display("FAIL reset_dcnt got %0d want 0", dcnt); end
        n_chk++; if (dout !== '0)    begin n_fail++; $display("FAIL reset_dout got %h want 0", dout); end
        n_chk++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_fail++; $display("FAIL reset_flags got ovf=%b udf=%b want 0 0", ovf, udf); end
        nrst = 1'b1;
        #1;
        n_chk++; if (rdy !== 1'b0)   begin n_fail++; $display("FAIL rdy_before_edge got %b want 0", rdy); end
        tick();
        n_chk++; if (rdy !== 1'b1)   begin n_fail++; $display("FAIL rdy_after_edge got %b want 1", rdy); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            din   = WIDTH'(i);
            sb.push_back(WIDTH'(i));
            tick();
            n_chk++; if (dcnt !== 9'(i + 1)) begin n_fail++; $display("FAIL fill_dcnt[%0d] got %0d want %0d", i, dcnt, i + 1); end
            n_chk++; if (afull !== ((i + 1) >= 252)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull, (i + 1) >= 252); end
            n_chk++; if (full !== (i == DEPTH - 1)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, full, i == DEPTH - 1); end
        end
        din = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        n_chk++; if (ovf !== 1'b1)       begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf); end
        n_chk++; if (dcnt !== 9'd256)    begin n_fail++; $display("FAIL ovf_dcnt got %0d want 256", dcnt); end
        n_chk++; if (full !== 1'b1)      begin n_fail++; $display("FAIL ovf_full got %b want 1", full); end
    endtask

    task automatic test_drain;
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1;
`ifdef FIFO_SYNC_PARAM_FWFT_EN
            exp_w = sb.pop_front();
            n_chk++; if (empty !== 1'b0) begin n_fail++; $display("FAIL drain_empty[%0d] got %b want 0", i, empty); end
            n_chk++; if (dout !== exp_w) begin n_fail++; $display("FAIL drain_dout[%0d] got %h want %h", i, dout, exp_w); end
            tick();
`else
            tick();
            exp_w = sb.pop_front();
            n_chk++; if (dout !== exp_w) begin n_fail++; $display("FAIL drain_dout[%0d] got %h want %h", i, dout, exp_w); end
`endif
        end
        rd_en = 1'b0;
        last_rd = exp_w;
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty_end got %b want 1", empty); end
        n_chk++; if (dcnt !== 9'd0)  begin n_fail++; $display("FAIL drain_dcnt_end got %0d want 0", dcnt); end
        n_chk++; if (udf !== 1'b0)   begin n_fail++; $display("FAIL udf_early got %b want 0", udf); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_chk++; if (udf !== 1'b1)   begin n_fail++; $display("FAIL udf_set got %b want 1", udf); end
        n_chk++; if (ovf !== 1'b1)   begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf); end
`ifndef FIFO_SYNC_PARAM_FWFT_EN
        n_chk++; if (dout !== last_rd) begin n_fail++; $display("FAIL dout_hold_udf got %h want %h", dout, last_rd); end
`endif
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_chk++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_fail++; $display("FAIL clr_flags got ovf=%b udf=%b want 0 0", ovf, udf); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 128; i++) begin
            wr_en = 1'b1;
            din   = 32'd1000 + WIDTH'(i);
            sb.push_back(din);
            tick();
        end
        wr_en = 1'b0;
        tick();
        n_chk++; if (dcnt !== 9'd128) begin n_fail++; $display("FAIL half_dcnt got %0d want 128", dcnt); end
        for (int c = 0; c < 1000; c++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            din   = 32'd5000 + WIDTH'(c);
`ifdef FIFO_SYNC_PARAM_FWFT_EN
            exp_w = sb.pop_front();
            n_chk++; if (dout !== exp_w) begin n_fail++; $display("FAIL stream_dout[%0d] got %h want %h", c, dout, exp_w); end
            sb.push_back(din);
            tick();
`else
            sb.push_back(din);
            tick();
            exp_w = sb.pop_front();
            n_chk++; if (dout !== exp_w) begin n_fail++; $display("FAIL stream_dout[%0d] got %h want %h", c, dout, exp_w); end
`endif
            n_chk++; if (dcnt !== 9'd128) begin n_fail++; $display("FAIL stream_dcnt[%0d] got %0d want 128", c, dcnt); end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        last_rd = exp_w;
    endtask

    task automatic test_clr;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        sb.delete();
        n_chk++; if (dcnt !== 9'd0) begin n_fail++; $display("FAIL clr_pre_dcnt got %0d want 0", dcnt); end
        for (int i = 0; i < 100; i++) begin
            wr_en = 1'b1;
            din   = 32'd7000 + WIDTH'(i);
            tick();
        end
        wr_en = 1'b0;
        n_chk++; if (dcnt !== 9'd100) begin n_fail++; $display("FAIL clr_fill_dcnt got %0d want 100", dcnt); end
        tick();
`ifdef FIFO_SYNC_PARAM_FWFT_EN
        last_rd = 32'd7000;
`endif
        clr   = 1'b1;
        wr_en = 1'b1;
        din   = 32'h0000_0BAD;
        tick();
        clr   = 1'b0;
        wr_en = 1'b0;
        n_chk++; if (dcnt !== 9'd0)  begin n_fail++; $display("FAIL clr_dcnt got %0d want 0", dcnt); end
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %b want 1", empty); end
        n_chk++; if (dout !== last_rd) begin n_fail++; $display("FAIL clr_dout_hold got %h want %h", dout, last_rd); end
        tick();
        n_chk++; if (dcnt !== 9'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL clr_write_dropped got dcnt=%0d empty=%b want 0 1", dcnt, empty); end
    endtask

    task automatic test_latency;
        wr_en = 1'b1;
        din   = 32'h0000_00A5;
        sb.push_back(din);
        tick();
        wr_en = 1'b0;
        n_chk++; if (dcnt !== 9'd1) begin n_fail++; $display("FAIL lat_dcnt got %0d want 1", dcnt); end
`ifdef FIFO_SYNC_PARAM_FWFT_EN
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fwft_empty_n got %b want 1", empty); end
        tick();
        exp_w = sb.pop_front();
        n_chk++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fwft_empty_n1 got %b want 0", empty); end
        n_chk++; if (dout !== exp_w) begin n_fail++; $display("FAIL fwft_dout got %h want %h", dout, exp_w); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`else
        n_chk++; if (empty !== 1'b0) begin n_fail++; $display("FAIL lat_empty got %b want 0", empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        exp_w = sb.pop_front();
        n_chk++; if (dout !== exp_w) begin n_fail++; $display("FAIL lat_dout got %h want %h", dout, exp_w); end
`endif
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL lat_empty_end got %b want 1", empty); end
        n_chk++; if (udf !== 1'b0)   begin n_fail++; $display("FAIL lat_udf got %b want 0", udf); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            din   = 32'h100 + WIDTH'(i);
            tick();
        end
        wr_en = 1'b0;
        #2 nrst = 1'b0;
        #1;
        n_chk++; if (rdy !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_rdy got %b want 0", rdy); end
        n_chk++; if (dcnt !== 9'd0)  begin n_fail++; $display("FAIL mid_rst_dcnt got %0d want 0", dcnt); end
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty got %b want 1", empty); end
        n_chk++; if (dout !== '0)    begin n_fail++; $display("FAIL mid_rst_dout got %h want 0", dout); end
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 32'h55;
        nrst  = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_chk++; if (rdy !== 1'b1)   begin n_fail++; $display("FAIL gate_rdy got %b want 1", rdy); end
        n_chk++; if (dcnt !== 9'd0)  begin n_fail++; $display("FAIL gate_dcnt got %0d want 0", dcnt); end
        n_chk++; if (udf !== 1'b0)   begin n_fail++; $display("FAIL gate_udf got %b want 0", udf); end
        tick();
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL gate_empty got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_clr();
        test_latency();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO that succeeds the fixed 256x32 FIFO: configurable width and depth, a full-range occupancy count, programmable almost-full/almost-empty flags, synchronous flush, sticky overflow/underflow error flags, and an optional first-word-fall-through read port. It buffers streaming sample words between producer and consumer blocks on the FPGA fabric clock domain.

## Interface
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 256, storage depth in words; power of two, >=4
- AFULL_TH, DEPTH-4, afull asserted when dcnt >= AFULL_TH
- AEMPTY_TH, 4, aempty asserted when dcnt <= AEMPTY_TH
- Reset: nrst, asynchronous, active-low. Clock: clk.
- clk  in  1  clock, all state updates on the rising edge
- nrst  in  1  asynchronous active-low reset
- rdy  out  1  block ready; low in reset, high from the first rising edge after nrst is released
- clr  in  1  synchronous flush, takes priority over wr_en and rd_en
- wr_en  in  1  write request
- din  in  WIDTH  write data
- full  out  1  no free entry
- afull  out  1  almost full
- rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
- dout  out  WIDTH  read data
- empty  out  1  no readable word
- aempty  out  1  almost empty
- dcnt  out  $clog2(DEPTH)+1  words held, 0..DEPTH inclusive
- ovf  out  1  sticky: write attempted while full
- udf  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x WIDTH array, write and read pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Write accepted iff wr_en & ~full & rdy; din is stored at the write pointer, which then increments.
- Read accepted iff rd_en & ~empty & rdy; the read pointer increments.
- Acceptance is evaluated independently: with both accepted, dcnt is unchanged. A write while full is dropped even if a read is accepted in the same cycle.
- dcnt +1 on accepted write only, -1 on accepted read only. full = (dcnt == DEPTH), empty = (dcnt == 0) in standard mode. afull and aempty are combinational compares on dcnt.
- ovf is set on wr_en & full. udf is set on rd_en & empty. Both are sticky and are cleared only by clr or nrst.
- clr: pointers, dcnt, ovf, udf and the FWFT valid bit return to 0 on the next edge. dout holds its value. Requests in the clr cycle are ignored.
- Reset values: rdy=0, full=0, afull=0, empty=1, aempty=1, dcnt=0, ovf=0, udf=0, dout=0.
- Reset mid-operation clears all contents immediately and asynchronously. rdy drops at once.
- While rdy=0, all requests are ignored and do not set the error flags.

## Timing
- Standard mode: dout is registered. The word read by an accepted read at edge N appears on dout after edge N and holds until the next accepted read.
- A word written at edge N makes empty fall after edge N. The write-to-read latency into an empty FIFO is 1 cycle.
- full rises after the edge that accepts the DEPTH-th word.
- Throughput is one write and one read per cycle, sustained.

## Configuration
- Macro: FIFO_SYNC_PARAM_FWFT_EN.
- Defined: first-word-fall-through mode. A registered output stage holds the head word. dout is valid whenever empty=0, and rd_en pops that word. A write at edge N into an empty FIFO shows on dout, with empty low, after edge N+1. dcnt includes the word in the output stage. full still means DEPTH words are held.
- Undefined: standard mode as described above.

## Test plan
- Reset, then release nrst -> rdy=1 after the first edge. empty=1, aempty=1, dcnt=0 and dout=0 throughout reset.
- DEPTH=256: write 0..255 continuously -> full=1 and dcnt=256 after the 256th write. afull rises at dcnt=252. A further wr_en sets ovf=1 and dcnt stays 256.
- Read all 256 words -> dout sequence 0..255 in order. After the last read empty=1. A further rd_en sets udf=1. clr then returns ovf=0 and udf=0.
- Half full (dcnt=128), wr_en=rd_en=1 for 1000 cycles -> dcnt stays 128, pointers wrap several times, and the data sequence has no gaps.
- clr asserted at dcnt=100 together with wr_en -> after the edge dcnt=0, empty=1, and the write is discarded.
- With FIFO_SYNC_PARAM_FWFT_EN: write 0xA5 into an empty FIFO -> empty falls and dout=0xA5 one cycle after the write edge, with no rd_en. rd_en then pops it -> empty=1.
